// File: rtl/jtag_bridge_pkg.sv
// Shared definitions for the single-chain JTAG-to-memory bridge:
// DR opcodes, FSM state encoding and status-bit offsets above the payload.
package jtag_bridge_pkg;

  // Opcode field, DR bits [DATA_W+1:DATA_W]
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SETA = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_RD   = 2'b11;

  // Memory handshake FSM
  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // Status bits in the captured DR, as offsets above DATA_W
  localparam int ST_BUSY = 0;
  localparam int ST_ERR  = 1;

  // WRITE and READ are the only opcodes that start a memory transaction
  function automatic logic is_mem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/jtag_mem_bridge_if.sv
// Memory-side req/ack bus of the bridge. The bridge drives it as master;
// a memory or bus adapter (or a testbench) connects as slave.
interface jtag_mem_bridge_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_ACK;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );
endinterface

// File: rtl/jtag_dr_shift.sv
// Generic capture/shift data register for a JTAG user chain.
// LSB-first: TDI enters at the MSB, TDO is bit 0. Priority is
// clear > capture > shift; enables are expected pre-qualified by SEL.
module jtag_dr_shift #(
  parameter int DR_W = 66
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            capture_en,
  input  logic            shift_en,
  input  logic [DR_W-1:0] cap_data,
  input  logic            tdi,
  output logic [DR_W-1:0] sr,
  output logic            tdo
);

  logic [DR_W-1:0] sr_q;
  logic [DR_W-1:0] sr_d;
  logic [DR_W-1:0] shifted;

  // One-bit right shift with TDI filling the MSB
  genvar gi;
  generate
    for (gi = 0; gi < DR_W; gi++) begin : g_shift
      if (gi == DR_W - 1) begin : g_msb
        assign shifted[gi] = tdi;
      end else begin : g_bit
        assign shifted[gi] = sr_q[gi+1];
      end
    end
  endgenerate

  // Next value: TAP reset clear, then capture, then shift
  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (capture_en) begin
      sr_d = cap_data;
    end else if (shift_en) begin
      sr_d = shifted;
    end
  end

  // Shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr  = sr_q;
  assign tdo = sr_q[0];

endmodule

// File: rtl/jtag_mem_bridge.sv
// Single-chain JTAG-to-memory bridge clocked on buffered TCK.
// One DR carries {opcode, payload}; WRITE/READ issue a req/ack memory
// transaction with auto-increment, and a sticky error flags commands
// that arrive while a transaction is still outstanding.
module jtag_mem_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,   // must not exceed DATA_W
  parameter int ADDR_INC = 8
) (
  input  logic                   TCK,
  input  logic                   RESET_N,
  input  logic                   TAP_RESET,
  input  logic                   SEL,
  input  logic                   CAPTURE,
  input  logic                   SHIFT,
  input  logic                   UPDATE,
  input  logic                   TDI,
  output logic                   TDO,
  output logic [5:0]             DBG,
  jtag_mem_bridge_if.master      mem
);

  localparam int DR_W = DATA_W + 2;

  logic [DR_W-1:0]   sr;
  logic [DR_W-1:0]   cap_data;
  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic              upd;
  logic              busy;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        last_op_q, last_op_d;
  logic              ack_seen_q, ack_seen_d;

  assign busy    = (state_q == S_REQ);
  assign opcode  = sr[DR_W-1:DATA_W];
  assign payload = sr[DATA_W-1:0];
  assign upd     = SEL & UPDATE;

  // Status word presented at Capture-DR: {err, busy, last read data}
  always_comb begin
    cap_data                  = '0;
    cap_data[DATA_W-1:0]      = rdata_q;
    cap_data[DATA_W+ST_BUSY]  = busy;
    cap_data[DATA_W+ST_ERR]   = err_q;
  end

  jtag_dr_shift #(
    .DR_W (DR_W)
  ) u_dr (
    .clk        (TCK),
    .rst_n      (RESET_N),
    .clr        (TAP_RESET),
    .capture_en (SEL & CAPTURE),
    .shift_en   (SEL & SHIFT),
    .cap_data   (cap_data),
    .tdi        (TDI),
    .sr         (sr),
    .tdo        (TDO)
  );

  // Next-state: ack completion first, then Update-DR decode. A SET_ADDR in
  // the ack cycle wins over the auto-increment since it targets the next
  // command; WRITE/READ in the ack cycle still sees REQ and is an overrun.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_d      = req_q;
    we_d       = we_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    last_op_d  = last_op_q;
    ack_seen_d = ack_seen_q;

    case (state_q)
      S_REQ: begin
        if (mem.MEM_ACK) begin
          state_d    = S_IDLE;
          req_d      = 1'b0;
          addr_d     = addr_q + ADDR_W'(ADDR_INC);
          ack_seen_d = 1'b1;
          if (!we_q) begin
            rdata_d = mem.MEM_RDATA;
          end
        end
      end
      default: begin
        // ACK while idle carries no meaning and is dropped
      end
    endcase

    if (upd) begin
      last_op_d = opcode;
      if (is_mem_op(opcode)) begin
        if (busy) begin
          err_d = 1'b1;
        end else begin
          state_d    = S_REQ;
          req_d      = 1'b1;
          we_d       = (opcode == OP_WR);
          mem_addr_d = addr_q;
          ack_seen_d = 1'b0;
          if (opcode == OP_WR) begin
            wdata_d = payload;
          end
        end
      end else if (opcode == OP_SETA) begin
        addr_d = payload[ADDR_W-1:0];
      end else if (payload[0]) begin
        // OP_NOP with bit0 set acknowledges the sticky error
        err_d = 1'b0;
      end
    end
  end

  // Bridge state registers; async reset aborts any outstanding request
  always_ff @(posedge TCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      last_op_q  <= OP_NOP;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      req_q      <= req_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      last_op_q  <= last_op_d;
      ack_seen_q <= ack_seen_d;
    end
  end

  assign mem.MEM_REQ   = req_q;
  assign mem.MEM_WE    = we_q;
  assign mem.MEM_ADDR  = mem_addr_q;
  assign mem.MEM_WDATA = wdata_q;

  assign DBG = {err_q, busy, state_q, last_op_q, ack_seen_q};

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Directed bench for jtag_mem_bridge: drives TAP controller strobes and
// acts as the memory slave, checking bus outputs and captured status.
module tb_jtag_mem_bridge;
  import jtag_bridge_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int DR_W   = DATA_W + 2;

  logic       TCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       TAP_RESET = 1'b0;
  logic       SEL = 1'b0;
  logic       CAPTURE = 1'b0;
  logic       SHIFT = 1'b0;
  logic       UPDATE = 1'b0;
  logic       TDI = 1'b0;
  logic       TDO;
  logic [5:0] DBG;

  int checks = 0;
  int failures = 0;

  logic [DR_W-1:0] dout;

  jtag_mem_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

  jtag_mem_bridge #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ADDR_INC (8)
  ) dut (
    .TCK       (TCK),
    .RESET_N   (RESET_N),
    .TAP_RESET (TAP_RESET),
    .SEL       (SEL),
    .CAPTURE   (CAPTURE),
    .SHIFT     (SHIFT),
    .UPDATE    (UPDATE),
    .TDI       (TDI),
    .TDO       (TDO),
    .DBG       (DBG),
    .mem       (mem_bus.slave)
  );

  always #5 TCK = ~TCK;

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Capture-DR then DR_W Shift-DR cycles; returns the captured word
  task automatic shift_dr(input logic [DR_W-1:0] din, output logic [DR_W-1:0] dq);
    SEL = 1'b1;
    CAPTURE = 1'b1;
    tick();
    CAPTURE = 1'b0;
    SHIFT = 1'b1;
    for (int i = 0; i < DR_W; i++) begin
      dq[i] = TDO;
      TDI = din[i];
      tick();
    end
    SHIFT = 1'b0;
    TDI = 1'b0;
  endtask

  task automatic do_update();
    SEL = 1'b1;
    UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
    SEL = 1'b0;
  endtask

  task automatic capture_only();
    SEL = 1'b1;
    CAPTURE = 1'b1;
    tick();
    CAPTURE = 1'b0;
    SEL = 1'b0;
  endtask

  task automatic cmd(input logic [DR_W-1:0] din);
    logic [DR_W-1:0] unused_q;
    shift_dr(din, unused_q);
    do_update();
  endtask

  task automatic ack(input logic [DATA_W-1:0] rd);
    mem_bus.MEM_RDATA = rd;
    mem_bus.MEM_ACK = 1'b1;
    tick();
    mem_bus.MEM_ACK = 1'b0;
    mem_bus.MEM_RDATA = '0;
  endtask

  initial begin
    mem_bus.MEM_ACK = 1'b0;
    mem_bus.MEM_RDATA = '0;

    // Reset state
    repeat (3) tick();
    RESET_N = 1'b1;
    tick();
    check("rst_req", mem_bus.MEM_REQ, 0);
    check("rst_addr", mem_bus.MEM_ADDR, 0);
    check("rst_wdata", mem_bus.MEM_WDATA, 0);
    check("rst_tdo", TDO, 0);
    check("rst_dbg", DBG, 0);

    // SET_ADDR 0x1000, WRITE with 1-cycle ack
    cmd({OP_SETA, 64'h1000});
    shift_dr({OP_WR, 64'h0123_4567_89AB_CDEF}, dout);
    check("wr_req_before_upd", mem_bus.MEM_REQ, 0);
    do_update();
    check("wr_req", mem_bus.MEM_REQ, 1);
    check("wr_we", mem_bus.MEM_WE, 1);
    check("wr_addr", mem_bus.MEM_ADDR, 32'h1000);
    check("wr_wdata", mem_bus.MEM_WDATA, 64'h0123_4567_89AB_CDEF);
    ack('0);
    check("wr_req_drop", mem_bus.MEM_REQ, 0);

    // READ at auto-incremented address, 1-cycle ack, then NOP capture
    cmd({OP_RD, 64'h0});
    check("rd_req", mem_bus.MEM_REQ, 1);
    check("rd_we", mem_bus.MEM_WE, 0);
    check("rd_addr", mem_bus.MEM_ADDR, 32'h1008);
    ack(64'hDEAD_BEEF_0000_0001);
    shift_dr({OP_NOP, 64'h0}, dout);
    check("rd_capture", dout, {2'b00, 64'hDEAD_BEEF_0000_0001});
    do_update();
    check("rd_dbg", DBG, 6'b000001);

    // READ with ack delayed 10 cycles; capture overlaps the pending request
    cmd({OP_RD, 64'h0});
    check("rd2_addr", mem_bus.MEM_ADDR, 32'h1010);
    fork
      begin
        shift_dr({OP_NOP, 64'h0}, dout);
        do_update();
      end
      begin
        repeat (10) tick();
        ack(64'h1122_3344_5566_7788);
      end
    join
    check("rd2_busy_capture", dout, {2'b01, 64'hDEAD_BEEF_0000_0001});
    check("rd2_req_drop", mem_bus.MEM_REQ, 0);
    shift_dr({OP_NOP, 64'h0}, dout);
    do_update();
    check("rd2_fresh_capture", dout, {2'b00, 64'h1122_3344_5566_7788});

    // Overrun: second WRITE while the first is unacknowledged
    cmd({OP_WR, 64'hAAAA_AAAA_AAAA_AAAA});
    check("ovr_addr", mem_bus.MEM_ADDR, 32'h1018);
    cmd({OP_WR, 64'h5555_5555_5555_5555});
    check("ovr_req_held", mem_bus.MEM_REQ, 1);
    check("ovr_wdata", mem_bus.MEM_WDATA, 64'hAAAA_AAAA_AAAA_AAAA);
    check("ovr_addr_held", mem_bus.MEM_ADDR, 32'h1018);
    check("ovr_err_dbg", DBG[5], 1);
    ack('0);
    repeat (3) tick();
    check("ovr_no_reissue", mem_bus.MEM_REQ, 0);
    shift_dr({OP_NOP, 64'h1}, dout);
    do_update();
    check("ovr_err_capture", dout, {2'b10, 64'h1122_3344_5566_7788});
    shift_dr({OP_NOP, 64'h0}, dout);
    do_update();
    check("ovr_err_cleared", dout, {2'b00, 64'h1122_3344_5566_7788});

    // Address wrap at 2^32
    cmd({OP_SETA, 64'hFFFF_FFF8});
    cmd({OP_WR, 64'h77});
    check("wrap_wr_addr", mem_bus.MEM_ADDR, 32'hFFFF_FFF8);
    ack('0);
    cmd({OP_RD, 64'h0});
    check("wrap_rd_addr", mem_bus.MEM_ADDR, 32'h0);
    ack(64'hCAFE_0001);

    // TAP_RESET mid-request clears sr only
    cmd({OP_RD, 64'h0});
    check("tapr_addr", mem_bus.MEM_ADDR, 32'h8);
    capture_only();
    check("tapr_tdo_before", TDO, 1);
    TAP_RESET = 1'b1;
    tick();
    TAP_RESET = 1'b0;
    check("tapr_tdo", TDO, 0);
    repeat (2) tick();
    check("tapr_req_kept", mem_bus.MEM_REQ, 1);
    ack(64'h3);
    check("tapr_req_drop", mem_bus.MEM_REQ, 0);

    // RESET_N mid-request aborts everything asynchronously
    cmd({OP_RD, 64'h0});
    check("arst_pre_req", mem_bus.MEM_REQ, 1);
    capture_only();
    check("arst_pre_tdo", TDO, 1);
    RESET_N = 1'b0;
    #1;
    check("arst_req", mem_bus.MEM_REQ, 0);
    check("arst_addr", mem_bus.MEM_ADDR, 0);
    check("arst_wdata", mem_bus.MEM_WDATA, 0);
    check("arst_tdo", TDO, 0);
    check("arst_dbg", DBG, 0);
    tick();
    RESET_N = 1'b1;
    tick();
    shift_dr({OP_NOP, 64'h0}, dout);
    do_update();
    check("arst_capture", dout, 0);
    cmd({OP_RD, 64'h0});
    check("arst_addr_cleared", mem_bus.MEM_ADDR, 32'h0);
    ack('0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
